// File: rtl/button_press_classifier_pkg.sv
// Shared types and elaboration-time helpers for the button press classifier.
// Also home of the log2 helper formerly local to the key debouncer.
package btn_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    GAP    = 3'd2,
    HOLD   = 3'd3,
    PRESS2 = 3'd4
  } state_t;

  function automatic int ms_to_cycles(input int freq_hz, input int ms);
    return freq_hz / 1000 * ms;
  endfunction

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/button_press_classifier_if.sv
// Debounced key level in, gesture event pulses out.
interface button_press_classifier_if;

  logic db_level;
  logic short_tick;
  logic long_tick;
  logic double_tick;
  logic busy;

  modport master (
    output db_level,
    input  short_tick,
    input  long_tick,
    input  double_tick,
    input  busy
  );

  modport slave (
    input  db_level,
    output short_tick,
    output long_tick,
    output double_tick,
    output busy
  );

endinterface

// File: rtl/button_press_classifier_press_timer.sv
// Saturating up-counter with synchronous clear; hit flags the last cycle before limit.
module press_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_clear,
  input  logic [W-1:0] i_limit,
  output logic         o_hit
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (r_cnt != '1) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_hit = (r_cnt == i_limit - 1'b1);

endmodule

// File: rtl/button_press_classifier.sv
// Classifies debounced key presses into short, long and double-click gestures,
// emitting a registered one-cycle pulse per gesture.
module button_press_classifier
  import btn_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int LONG_MS     = 800,
  parameter int DOUBLE_MS   = 250
) (
  input logic                      clk,
  input logic                      reset,
  button_press_classifier_if.slave bus
);

  localparam int LONG_CYC = ms_to_cycles(CLK_FREQ_HZ, LONG_MS);
  localparam int DBL_CYC  = ms_to_cycles(CLK_FREQ_HZ, DOUBLE_MS);
  localparam int MAX_CYC  = (LONG_CYC > DBL_CYC) ? LONG_CYC : DBL_CYC;
  localparam int W        = clog2(MAX_CYC + 1);
  localparam logic [W-1:0] LONG_LIM = W'(LONG_CYC);
  localparam logic [W-1:0] DBL_LIM  = W'(DBL_CYC);

  state_t       r_state;
  state_t       w_next;
  logic         r_lvl_q;
  logic         w_rise;
  logic         w_hit;
  logic         w_clear;
  logic [W-1:0] w_limit;
  logic         w_short;
  logic         w_long;
  logic         w_double;
  logic         w_busy;
  logic         r_short;
  logic         r_long;
  logic         r_double;
  logic         r_busy;

  // lvl_q resets high so a key held through reset needs a fresh press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_lvl_q <= 1'b1;
    else       r_lvl_q <= bus.db_level;
  end

  assign w_rise  = bus.db_level & ~r_lvl_q;
  assign w_clear = (w_next != r_state);
  assign w_limit = (r_state == GAP) ? DBL_LIM : LONG_LIM;

  press_timer #(
    .W(W)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_clear),
    .i_limit (w_limit),
    .o_hit   (w_hit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Release beats the long timeout in PRESS1; a press beats the timeout in GAP.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_rise) w_next = PRESS1;
      PRESS1: begin
        if (!bus.db_level) w_next = GAP;
        else if (w_hit)    w_next = HOLD;
      end
      GAP: begin
        if (bus.db_level) w_next = PRESS2;
        else if (w_hit)   w_next = IDLE;
      end
      HOLD:    if (!bus.db_level) w_next = IDLE;
      PRESS2:  if (!bus.db_level) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_short  = (r_state == GAP)    && !bus.db_level && w_hit;
    w_long   = (r_state == PRESS1) &&  bus.db_level && w_hit;
    w_double = (r_state == GAP)    &&  bus.db_level;
    w_busy   = (w_next != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_short  <= 1'b0;
      r_long   <= 1'b0;
      r_double <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_short  <= w_short;
      r_long   <= w_long;
      r_double <= w_double;
      r_busy   <= w_busy;
    end
  end

  assign bus.short_tick  = r_short;
  assign bus.long_tick   = r_long;
  assign bus.double_tick = r_double;
  assign bus.busy        = r_busy;

endmodule

// File: tb/tb_button_press_classifier.sv
// Directed gesture vectors for button_press_classifier with LONG_CYC=10, DBL_CYC=4.
module tb_button_press_classifier;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  button_press_classifier_if bus ();

  button_press_classifier #(
    .CLK_FREQ_HZ (1000),
    .LONG_MS     (10),
    .DOUBLE_MS   (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int nChecks = 0;
  int nFails  = 0;

  // Each vector starts idle; bit c of pat is db_level for cycle c, and a tick
  // observed at cycle c was produced by the clock edge ending cycle c-1.
  typedef struct {
    string       name;
    logic [63:0] pat;
    int          expShort;
    int          expLong;
    int          expDouble;
    int          expFirstTick;
    int          busyZeroCyc;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [63:0] pulses(input int a0, input int a1, input int b0, input int b1);
    logic [63:0] p;
    p = '0;
    for (int i = 0; i < 64; i++)
      if ((i >= a0 && i < a1) || (i >= b0 && i < b1)) p[i] = 1'b1;
    return p;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    nChecks++;
    if (actual != expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    int   nS;
    int   nL;
    int   nD;
    int   first;
    logic busyLog[40];
    nS = 0; nL = 0; nD = 0; first = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.short_tick)  nS++;
      if (bus.long_tick)   nL++;
      if (bus.double_tick) nD++;
      if ((bus.short_tick || bus.long_tick || bus.double_tick) && first < 0) first = c;
      busyLog[c] = bus.busy;
      bus.db_level = v.pat[c];
    end
    checkOutput({v.name, " short count"}, nS, v.expShort);
    checkOutput({v.name, " long count"}, nL, v.expLong);
    checkOutput({v.name, " double count"}, nD, v.expDouble);
    checkOutput({v.name, " first tick cycle"}, first, v.expFirstTick);
    checkOutput({v.name, " busy before tick"}, int'(busyLog[v.expFirstTick-1]), 1);
    checkOutput({v.name, " busy after gesture"}, int'(busyLog[v.busyZeroCyc]), 0);
  endtask

  initial begin
    int ticks;
    int busyHigh;

    vecs[0] = '{"short",           pulses(1, 4, 0, 0),  1, 0, 0,  9, 10};
    vecs[1] = '{"long",            pulses(1, 21, 0, 0), 0, 1, 0, 12, 22};
    vecs[2] = '{"double",          pulses(1, 3, 5, 8),  0, 0, 1,  6, 10};
    vecs[3] = '{"doubleHeld",      pulses(1, 3, 5, 20), 0, 0, 1,  6, 22};
    vecs[4] = '{"releaseAtLimit",  pulses(1, 11, 0, 0), 1, 0, 0, 16, 17};
    vecs[5] = '{"holdToLimit",     pulses(1, 12, 0, 0), 0, 1, 0, 12, 14};
    vecs[6] = '{"pressAtGapLimit", pulses(1, 3, 7, 9),  0, 0, 1,  8, 11};
    vecs[7] = '{"pressAfterGap",   pulses(1, 3, 8, 10), 2, 0, 0,  8, 17};

    // Key already held while reset is asserted and released.
    reset = 1'b1;
    bus.db_level = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset busy", int'(bus.busy), 0);
    checkOutput("reset ticks", int'(bus.short_tick) + int'(bus.long_tick) + int'(bus.double_tick), 0);
    reset = 1'b0;
    ticks = 0; busyHigh = 0;
    repeat (15) begin
      @(negedge clk);
      ticks += int'(bus.short_tick) + int'(bus.long_tick) + int'(bus.double_tick);
      busyHigh += int'(bus.busy);
    end
    checkOutput("held through reset ticks", ticks, 0);
    checkOutput("held through reset busy", busyHigh, 0);
    bus.db_level = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

    // Reset in the middle of a long hold.
    @(negedge clk);
    bus.db_level = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("mid-hold busy before reset", int'(bus.busy), 1);
    #2 reset = 1'b1;
    #1;
    checkOutput("mid-hold busy at reset", int'(bus.busy), 0);
    checkOutput("mid-hold ticks at reset", int'(bus.short_tick) + int'(bus.long_tick) + int'(bus.double_tick), 0);
    @(negedge clk);
    reset = 1'b0;
    ticks = 0; busyHigh = 0;
    repeat (20) begin
      @(negedge clk);
      ticks += int'(bus.short_tick) + int'(bus.long_tick) + int'(bus.double_tick);
      busyHigh += int'(bus.busy);
    end
    checkOutput("after mid-hold reset ticks", ticks, 0);
    checkOutput("after mid-hold reset busy", busyHigh, 0);
    bus.db_level = 1'b0;
    repeat (3) @(negedge clk);

    // Classifier still works normally after the aborted gesture.
    applyStimulus(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
